slice_config_loader: RTL and testbench

- Loads one fractured logic slice's configuration from a word-wide stream.
- Assembles every LUT's config image plus the carry-chain enable in a shadow register, then commits it atomically with a one-cycle config_en pulse.
- Sits between the fabric configuration bus and one slice instance; the slice never sees a partial image.

---
 rtl/slice_cfg_pkg.sv | 30 +++
 rtl/slice_cfg_shadow.sv | 61 ++++++
 rtl/slice_config_loader.sv | 135 +++++++++++++
 tb/tb_slice_config_loader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_cfg_pkg.sv
// Shared types and sizing helpers for the slice configuration loader.
package slice_cfg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StCommit,
        StDone,
        StError
    } cfg_state_e;

    localparam int unsigned MaxWordW = 64;

    // Stream bit 0 is the carry-chain select; every LUT image follows it.
    function automatic int unsigned total_bits(input int unsigned num_luts,
                                               input int unsigned l_mem_size);
        return 1 + num_luts * 2 * l_mem_size;
    endfunction

    function automatic int unsigned n_words(input int unsigned tot, input int unsigned word_w);
        return (tot + word_w - 1) / word_w;
    endfunction

    function automatic logic [MaxWordW-1:0] checksum_step(input logic [MaxWordW-1:0] acc,
                                                          input logic [MaxWordW-1:0] word);
        return acc ^ word;
    endfunction

endpackage

// File: rtl/slice_cfg_shadow.sv
// Shadow image register: scatters each accepted word into its stream bit positions.
module slice_cfg_shadow
    import slice_cfg_pkg::*;
#(
    parameter int unsigned NUM_LUTS   = 4,
    parameter int unsigned L_MEM_SIZE = 17,
    parameter int unsigned WORD_W     = 8
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     clr_i,
    input  logic                                     wr_en_i,
    input  logic [WORD_W-1:0]                        word_i,
    output logic [$clog2(n_words(total_bits(NUM_LUTS, L_MEM_SIZE), WORD_W) + 1)-1:0] word_cnt_o,
    output logic [NUM_LUTS*2*L_MEM_SIZE-1:0]         luts_o,
    output logic                                     pend_cc_o
);

    localparam int unsigned TotalBits = total_bits(NUM_LUTS, L_MEM_SIZE);
    localparam int unsigned NWords    = n_words(TotalBits, WORD_W);
    localparam int unsigned CntW      = $clog2(NWords + 1);

    logic [TotalBits-1:0] img_q, img_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    // Bits past TotalBits in the final word have no destination and are dropped.
    always_comb begin
        img_d = img_q;
        if (wr_en_i) begin
            for (int k = 0; k < TotalBits; k++) begin
                if (k / WORD_W == int'(cnt_q)) begin
                    img_d[k] = word_i[k % WORD_W];
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (wr_en_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            img_q <= '0;
            cnt_q <= '0;
        end else begin
            img_q <= img_d;
            cnt_q <= cnt_d;
        end
    end

    assign word_cnt_o = cnt_q;
    assign luts_o     = img_q[TotalBits-1:1];
    assign pend_cc_o  = img_q[0];

endmodule

// File: rtl/slice_config_loader.sv
// Streams a slice config image into a shadow register and commits it with a one-cycle strobe.
// Define SLICE_CFG_CHECKSUM_EN to require a trailing XOR checksum word before commit.
module slice_config_loader
    import slice_cfg_pkg::*;
#(
    parameter int unsigned S_XX_BASE  = 4,
    parameter int unsigned L_MEM_SIZE = 2**S_XX_BASE + 1,
    parameter int unsigned NUM_LUTS   = 4,
    parameter int unsigned WORD_W     = 8
) (
    input  logic                              config_clk,
    input  logic                              config_rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [WORD_W-1:0]                 in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [NUM_LUTS*2*L_MEM_SIZE-1:0]  luts_config_out,
    output logic                              config_en,
    output logic                              config_use_cc,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam int unsigned TotalBits = total_bits(NUM_LUTS, L_MEM_SIZE);
    localparam int unsigned NWords    = n_words(TotalBits, WORD_W);
    localparam int unsigned CntW      = $clog2(NWords + 1);

    cfg_state_e      state_q, state_d;
    logic [CntW-1:0] word_cnt;
    logic            pend_cc;
    logic            use_cc_q;
    logic            accept;
    logic            last_word;
    logic            load_start;
    logic            shadow_wr;

    assign accept     = in_valid && in_ready;
    assign last_word  = (word_cnt == CntW'(NWords - 1));
    assign load_start = (state_q == StIdle || state_q == StDone || state_q == StError) &&
                        start && !abort;
    assign shadow_wr  = (state_q == StLoad) && accept && !abort;

    slice_cfg_shadow #(
        .NUM_LUTS   (NUM_LUTS),
        .L_MEM_SIZE (L_MEM_SIZE),
        .WORD_W     (WORD_W)
    ) u_shadow (
        .clk_i      (config_clk),
        .rst_i      (config_rst),
        .clr_i      (load_start),
        .wr_en_i    (shadow_wr),
        .word_i     (in_data),
        .word_cnt_o (word_cnt),
        .luts_o     (luts_config_out),
        .pend_cc_o  (pend_cc)
    );

`ifdef SLICE_CFG_CHECKSUM_EN
    logic [WORD_W-1:0] cksum_q;
    logic              cksum_ok;

    always_ff @(posedge config_clk) begin
        if (config_rst || load_start) begin
            cksum_q <= '0;
        end else if (shadow_wr) begin
            cksum_q <= WORD_W'(checksum_step(MaxWordW'(cksum_q), MaxWordW'(in_data)));
        end
    end

    assign cksum_ok = (in_data == cksum_q);
`endif

    always_ff @(posedge config_clk) begin
        if (config_rst) begin
            state_q  <= StIdle;
            use_cc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StCommit) begin
                use_cc_q <= pend_cc;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (load_start) state_d = StLoad;
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (accept && last_word) begin
`ifdef SLICE_CFG_CHECKSUM_EN
                    state_d = StCheck;
`else
                    state_d = StCommit;
`endif
                end
            end
`ifdef SLICE_CFG_CHECKSUM_EN
            StCheck: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (accept) begin
                    state_d = cksum_ok ? StCommit : StError;
                end
            end
            StError: begin
                if (load_start) state_d = StLoad;
            end
`endif
            StCommit: state_d = StDone;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready      = (state_q == StLoad);
        busy          = (state_q == StLoad) || (state_q == StCommit);
        config_en     = (state_q == StCommit);
        done          = (state_q == StDone);
        err           = 1'b0;
        config_use_cc = use_cc_q;
`ifdef SLICE_CFG_CHECKSUM_EN
        in_ready      = in_ready || (state_q == StCheck);
        busy          = busy || (state_q == StCheck);
        err           = (state_q == StError);
`endif
    end

endmodule

// File: tb/tb_slice_config_loader.sv
// Randomized self-checking bench for slice_config_loader against a stream-level image model.
module tb_slice_config_loader;

    localparam int unsigned NW       = 18;
    localparam int unsigned LUT_BITS = 136;

    logic                clk = 1'b0;
    logic                config_rst;
    logic                start;
    logic                abort;
    logic [7:0]          in_data;
    logic                in_valid;
    logic                in_ready;
    logic [LUT_BITS-1:0] luts_config_out;
    logic                config_en;
    logic                config_use_cc;
    logic                busy;
    logic                done;
    logic                err;

    slice_config_loader dut (
        .config_clk      (clk),
        .config_rst      (config_rst),
        .start           (start),
        .abort           (abort),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .luts_config_out (luts_config_out),
        .config_en       (config_en),
        .config_use_cc   (config_use_cc),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_pass    = 0;
    int en_pulses = 0;

    // Model: the shadow is the concatenated word stream, LSB first; bit 0 is use_cc.
    logic [7:0]        words [NW];
    logic [NW*8-1:0]   model_stream;
    logic              model_cc;

    always @(negedge clk) if (config_en === 1'b1) en_pulses++;

    task automatic start_load();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_words(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = words[i];
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL in_ready_load word %0d: got %b want 1", i, in_ready);
            else n_pass++;
            @(posedge clk); #1;
            in_valid = 1'b0;
            model_stream[i*8 +: 8] = words[i];
        end
    endtask

`ifdef SLICE_CFG_CHECKSUM_EN
    function automatic logic [7:0] xor_words();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < NW; i++) x ^= words[i];
        return x;
    endfunction

    task automatic send_check(input logic [7:0] value);
        in_valid = 1'b1;
        in_data  = value;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL in_ready_check: got %b want 1", in_ready);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask
`endif

    task automatic expect_commit(input string name);
        int p0;
        p0 = en_pulses;
        @(negedge clk);
        n_checks++;
        if (config_en !== 1'b1) $display("FAIL %s commit_strobe: got %b want 1", name, config_en);
        else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (config_en !== 1'b0 || done !== 1'b1 || busy !== 1'b0)
            $display("FAIL %s done_state: en=%b done=%b busy=%b want 0 1 0",
                     name, config_en, done, busy);
        else n_pass++;
        n_checks++;
        if (luts_config_out !== model_stream[LUT_BITS:1])
            $display("FAIL %s image: got %h want %h", name, luts_config_out,
                     model_stream[LUT_BITS:1]);
        else n_pass++;
        n_checks++;
        if (config_use_cc !== model_stream[0])
            $display("FAIL %s use_cc: got %b want %b", name, config_use_cc, model_stream[0]);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (en_pulses - p0 !== 1) $display("FAIL %s pulse_count: got %0d want 1", name, en_pulses - p0);
        else n_pass++;
        model_cc = model_stream[0];
    endtask

    task automatic full_load(input string name, input int gap_pct);
        start_load();
        send_words(NW, gap_pct);
`ifdef SLICE_CFG_CHECKSUM_EN
        send_check(xor_words());
`endif
        expect_commit(name);
    endtask

    task automatic test_reset();
        config_rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 config_rst = 1'b0;
        model_stream = '0;
        model_cc     = 1'b0;
        @(negedge clk);
        n_checks++;
        if (luts_config_out !== '0 || config_use_cc !== 1'b0)
            $display("FAIL reset_image: luts=%h cc=%b want 0 0", luts_config_out, config_use_cc);
        else n_pass++;
        n_checks++;
        if ({config_en, done, busy, err, in_ready} !== 5'b0)
            $display("FAIL reset_flags: en/done/busy/err/rdy=%b want 00000",
                     {config_en, done, busy, err, in_ready});
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < NW; i++) words[i] = 8'hFF;
        full_load("all_ones", 0);
        n_checks++;
        if (luts_config_out !== {LUT_BITS{1'b1}} || config_use_cc !== 1'b1)
            $display("FAIL all_ones_const: luts=%h cc=%b want all ones, 1",
                     luts_config_out, config_use_cc);
        else n_pass++;
    endtask

    task automatic test_single_bit();
        logic [LUT_BITS-1:0] exp_img;
        exp_img = '0;
        exp_img[0] = 1'b1;
        for (int i = 0; i < NW; i++) words[i] = 8'h00;
        words[0] = 8'h02;
        full_load("single_bit", 0);
        n_checks++;
        if (luts_config_out !== exp_img || config_use_cc !== 1'b0)
            $display("FAIL single_bit_const: luts=%h cc=%b want %h 0",
                     luts_config_out, config_use_cc, exp_img);
        else n_pass++;
    endtask

    task automatic test_ready_outside();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL ready_outside cycle %0d: got %b want 0", i, in_ready);
            else n_pass++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (luts_config_out !== model_stream[LUT_BITS:1])
            $display("FAIL ready_outside_image: got %h want %h", luts_config_out,
                     model_stream[LUT_BITS:1]);
        else n_pass++;
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NW; i++) words[i] = 8'($urandom);
            full_load("gaps", 40);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NW; i++) words[i] = 8'($urandom);
            full_load("back_to_back", 0);
        end
    endtask

    task automatic test_abort();
        int p0;
        p0 = en_pulses;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1)
            $display("FAIL abort_beats_start: busy=%b done=%b want 0 1", busy, done);
        else n_pass++;
        @(posedge clk); #1;
        for (int i = 0; i < NW; i++) words[i] = 8'($urandom);
        words[0][0] = ~model_cc;
        start_load();
        send_words(10, 20);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL abort_idle: busy=%b done=%b rdy=%b want 0 0 0", busy, done, in_ready);
        else n_pass++;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (en_pulses - p0 !== 0) $display("FAIL abort_no_commit: got %0d pulses want 0", en_pulses - p0);
        else n_pass++;
        n_checks++;
        if (config_use_cc !== model_cc) $display("FAIL abort_use_cc: got %b want %b", config_use_cc, model_cc);
        else n_pass++;
        n_checks++;
        if (luts_config_out !== model_stream[LUT_BITS:1])
            $display("FAIL abort_partial: got %h want %h", luts_config_out, model_stream[LUT_BITS:1]);
        else n_pass++;
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < NW; i++) words[i] = 8'($urandom) | 8'h01;
        start_load();
        send_words(9, 0);
        in_valid   = 1'b1;
        in_data    = words[9];
        config_rst = 1'b1;
        @(posedge clk); #1;
        config_rst = 1'b0;
        in_valid   = 1'b0;
        model_stream = '0;
        model_cc     = 1'b0;
        @(negedge clk);
        n_checks++;
        if (luts_config_out !== '0 || {config_use_cc, config_en, done, busy, err} !== 5'b0)
            $display("FAIL midload_reset: luts=%h cc/en/done/busy/err=%b want 0",
                     luts_config_out, {config_use_cc, config_en, done, busy, err});
        else n_pass++;
        @(posedge clk); #1;
        full_load("after_reset", 10);
    endtask

`ifdef SLICE_CFG_CHECKSUM_EN
    task automatic test_checksum();
        int p0;
        for (int i = 0; i < NW; i++) words[i] = 8'h5A;
        start_load();
        send_words(NW, 0);
        send_check(8'h00);
        expect_commit("cksum_match");
        for (int i = 0; i < NW; i++) words[i] = 8'hFF;
        full_load("cksum_prep", 0);
        for (int i = 0; i < NW; i++) words[i] = 8'h5A;
        p0 = en_pulses;
        start_load();
        send_words(NW, 0);
        send_check(8'h01);
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || config_en !== 1'b0 || done !== 1'b0)
            $display("FAIL cksum_mismatch: err=%b en=%b done=%b want 1 0 0", err, config_en, done);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (en_pulses - p0 !== 0 || config_use_cc !== model_cc)
            $display("FAIL cksum_no_commit: pulses=%0d cc=%b want 0 %b",
                     en_pulses - p0, config_use_cc, model_cc);
        else n_pass++;
        start_load();
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) $display("FAIL cksum_clear: err=%b busy=%b want 0 1", err, busy);
        else n_pass++;
        @(posedge clk); #1;
        send_words(NW, 0);
        send_check(xor_words());
        expect_commit("cksum_recover");
    endtask
`endif

    initial begin
        test_reset();
        test_all_ones();
        test_single_bit();
        test_ready_outside();
        test_gaps();
        test_back_to_back();
        test_abort();
        test_reset_midload();
`ifdef SLICE_CFG_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
